// File: rtl/fpga_top_mul_pkg.sv
// ---------------------------------------------------------------------------
// fpga_top_mul_pkg
// Shared constants and helper functions for the pipelined multiplier
// (fpga_top_mul_pipe) and its width-reduction stage.
//
// Contents:
//   MUL_MAX_STAGE  - deepest pipeline the multiplier may be built with
//   MUL_CALC_WIDTH - width of the helper function results below
//   prod_width     - bit width of the exact product of two operands
//   sat_max        - largest value representable in a w-bit result
//   sat_min        - smallest value representable in a w-bit result
// The saturation helpers return MUL_CALC_WIDTH-bit two's complement patterns;
// callers slice off the low w bits they need.
// ---------------------------------------------------------------------------
package fpga_top_mul_pkg;

   localparam int MUL_MAX_STAGE  = 8;
   localparam int MUL_CALC_WIDTH = 64;

   // Number of bits needed to hold the exact product of an a-bit and a b-bit
   // operand, regardless of operand signedness.
   function automatic int prod_width(input int a, input int b);
      return a + b;
   endfunction

   // Upper clamp value for a w-bit result: 2^(w-1)-1 when signed,
   // 2^w-1 when unsigned.
   function automatic logic [MUL_CALC_WIDTH-1:0] sat_max(input int w, input bit sgn);
      logic [MUL_CALC_WIDTH-1:0] one;
      one = MUL_CALC_WIDTH'(1);
      if (sgn) begin
         return (one << (w - 1)) - one;
      end
      return (one << w) - one;
   endfunction

   // Lower clamp value for a w-bit result: -2^(w-1) when signed, 0 when
   // unsigned. Inverting 2^(w-1)-1 yields -2^(w-1) in two's complement.
   function automatic logic [MUL_CALC_WIDTH-1:0] sat_min(input int w, input bit sgn);
      logic [MUL_CALC_WIDTH-1:0] one;
      one = MUL_CALC_WIDTH'(1);
      if (sgn) begin
         return ~((one << (w - 1)) - one);
      end
      return '0;
   endfunction

endpackage

// File: rtl/fpga_top_mul_pipe_reduce.sv
// ---------------------------------------------------------------------------
// fpga_top_mul_pipe_reduce
// Combinational width reduction for the multiplier result. Takes the exact
// product (IN_WIDTH bits, two's complement) and squeezes it into DOUT_WIDTH
// bits either by truncation or by saturation, and flags products that do not
// fit in the result range.
//
// Parameters:
//   IN_WIDTH      - width of the exact signed product
//   DOUT_WIDTH    - width of the reduced result
//   RESULT_SIGNED - 1 = result range is two's complement, 0 = unsigned
//   SATURATE      - 0 = keep low bits, 1 = clamp to the representable range
//
// Ports:
//   prod  in   IN_WIDTH    exact product
//   dout  out  DOUT_WIDTH  reduced result
//   ovf   out  1           product does not fit in the result range
// ---------------------------------------------------------------------------
module fpga_top_mul_pipe_reduce
   import fpga_top_mul_pkg::*;
#(
   parameter int IN_WIDTH      = 20,
   parameter int DOUT_WIDTH    = 14,
   parameter int RESULT_SIGNED = 0,
   parameter int SATURATE      = 0
) (
   input  logic [IN_WIDTH-1:0]   prod,
   output logic [DOUT_WIDTH-1:0] dout,
   output logic                  ovf
);

   generate
      if (DOUT_WIDTH >= IN_WIDTH - 1) begin : g_extend
         // The exact product of the two operands always fits in IN_WIDTH-1
         // bits of the result signedness, so a wide enough result never
         // overflows. Sign extension also covers the unsigned case because an
         // unsigned product always has a zero top bit.
         always_comb begin
            dout = DOUT_WIDTH'(signed'(prod));
            ovf  = 1'b0;
         end
      end else begin : g_reduce
         localparam logic [MUL_CALC_WIDTH-1:0] MaxFull = sat_max(DOUT_WIDTH, RESULT_SIGNED != 0);
         localparam logic [MUL_CALC_WIDTH-1:0] MinFull = sat_min(DOUT_WIDTH, RESULT_SIGNED != 0);
         localparam logic [DOUT_WIDTH-1:0]     MaxVal  = MaxFull[DOUT_WIDTH-1:0];
         localparam logic [DOUT_WIDTH-1:0]     MinVal  = MinFull[DOUT_WIDTH-1:0];

         logic fits;
         logic negative;

         // A signed result fits when every bit from the result's sign bit
         // upward is a copy of the product's sign; an unsigned result fits
         // when every bit above the result is zero. Only a signed product can
         // be negative, so an unsigned result can only clamp to the maximum.
         always_comb begin
            negative = (RESULT_SIGNED != 0) && prod[IN_WIDTH-1];
            if (RESULT_SIGNED != 0) begin
               fits = (prod[IN_WIDTH-1:DOUT_WIDTH-1] == '0) ||
                      (prod[IN_WIDTH-1:DOUT_WIDTH-1] == '1);
            end else begin
               fits = (prod[IN_WIDTH-1:DOUT_WIDTH] == '0);
            end
            ovf = !fits;
            if ((SATURATE != 0) && !fits) begin
               dout = negative ? MinVal : MaxVal;
            end else begin
               dout = prod[DOUT_WIDTH-1:0];
            end
         end
      end
   endgenerate

endmodule

// File: rtl/fpga_top_mul_pipe.sv
// ---------------------------------------------------------------------------
// fpga_top_mul_pipe
// Parametrised pipelined integer multiplier with a valid/ready handshake.
// Each operand may be signed or unsigned; the result is signed when either
// operand is. The exact product is reduced to DOUT_WIDTH bits (truncate or
// saturate) in the last stage, with an overflow flag aligned to the result.
//
// Pipeline layout (NUM_STAGE registers, 1..MUL_MAX_STAGE):
//   NUM_STAGE = 1 : multiply + reduce feed the single output register
//   NUM_STAGE = 2 : operand registers, then multiply + reduce into output
//   NUM_STAGE >= 3: operand registers, multiply into the first product
//                   register, further product registers for retiming,
//                   then reduce into the output register
// A beat presented in one cycle is valid at the output NUM_STAGE clock edges
// later when nothing stalls. The whole pipeline stalls when the output holds
// an unconsumed result; bubbles shift along with real beats.
//
// Ports:
//   ap_clk     in   1           clock
//   ap_rst     in   1           synchronous active-high reset
//   in_valid   in   1           operand beat valid
//   in_ready   out  1           block accepts a beat this cycle
//   din0       in   DIN0_WIDTH  operand 0
//   din1       in   DIN1_WIDTH  operand 1
//   out_valid  out  1           result valid
//   out_ready  in   1           downstream accepts the result
//   dout       out  DOUT_WIDTH  result
//   ovf        out  1           product did not fit in DOUT_WIDTH
// ---------------------------------------------------------------------------
module fpga_top_mul_pipe
   import fpga_top_mul_pkg::*;
#(
   parameter int DIN0_WIDTH = 10,
   parameter int DIN1_WIDTH = 9,
   parameter int DOUT_WIDTH = 14,
   parameter int NUM_STAGE  = 3,
   parameter int SIGNED0    = 0,
   parameter int SIGNED1    = 0,
   parameter int SATURATE   = 0
) (
   input  logic                  ap_clk,
   input  logic                  ap_rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DIN0_WIDTH-1:0] din0,
   input  logic [DIN1_WIDTH-1:0] din1,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DOUT_WIDTH-1:0] dout,
   output logic                  ovf
);

   localparam int ProdBits     = prod_width(DIN0_WIDTH, DIN1_WIDTH);
   localparam int ProdWidth    = ProdBits + 1;
   localparam int ResultSigned = ((SIGNED0 != 0) || (SIGNED1 != 0)) ? 1 : 0;

   generate
      if ((NUM_STAGE < 1) || (NUM_STAGE > MUL_MAX_STAGE)) begin : g_bad_stage
         $error("fpga_top_mul_pipe: NUM_STAGE must be in 1..%0d", MUL_MAX_STAGE);
      end
   endgenerate

   logic                  adv;
   logic                  accept;
   logic [NUM_STAGE-1:0]  validReg;
   logic [DIN0_WIDTH:0]   op0Ext;
   logic [DIN1_WIDTH:0]   op1Ext;
   logic [ProdWidth-1:0]  finalProd;
   logic [DOUT_WIDTH-1:0] redDout;
   logic                  redOvf;
   logic [DOUT_WIDTH-1:0] doutReg;
   logic                  ovfReg;

   // Exact product of two extended operands. Both are widened to the product
   // width as signed values; the true product always fits, so keeping the low
   // ProdWidth bits of the multiply loses nothing.
   function automatic logic [ProdWidth-1:0] mulExt(input logic [DIN0_WIDTH:0] a,
                                                  input logic [DIN1_WIDTH:0] b);
      logic signed [ProdWidth-1:0] sa;
      logic signed [ProdWidth-1:0] sb;
      sa = ProdWidth'(signed'(a));
      sb = ProdWidth'(signed'(b));
      return sa * sb;
   endfunction

   // The whole pipeline advances whenever the output slot is empty or being
   // consumed. Nothing is accepted while reset is held so that no beat can
   // slip in on the reset edge.
   assign adv       = !validReg[NUM_STAGE-1] || out_ready;
   assign in_ready  = adv && !ap_rst;
   assign accept    = in_valid && in_ready;
   assign out_valid = validReg[NUM_STAGE-1];
   assign dout      = doutReg;
   assign ovf       = ovfReg;

   // Operands get one extra bit so unsigned and signed values can share a
   // single signed multiplier: zero extension for unsigned, sign extension
   // for two's complement.
   always_comb begin
      op0Ext = (SIGNED0 != 0) ? {din0[DIN0_WIDTH-1], din0} : {1'b0, din0};
      op1Ext = (SIGNED1 != 0) ? {din1[DIN1_WIDTH-1], din1} : {1'b0, din1};
   end

   // Stage valid bits form a plain shift register. The accept strobe enters
   // at the bottom; an idle cycle enters as a zero, so bubbles are kept in
   // place rather than squeezed out.
   always_ff @(posedge ap_clk) begin
      if (ap_rst) begin
         validReg <= '0;
      end else if (adv) begin
         validReg <= NUM_STAGE'({validReg, accept});
      end
   end

   generate
      if (NUM_STAGE == 1) begin : g_one
         // Single stage: multiply and reduce straight from the ports into
         // the output register.
         assign finalProd = mulExt(op0Ext, op1Ext);
      end else begin : g_multi
         logic [DIN0_WIDTH:0] op0Reg;
         logic [DIN1_WIDTH:0] op1Reg;

         // First stage captures the extended operands so the multiplier
         // starts from registered inputs.
         always_ff @(posedge ap_clk) begin
            if (ap_rst) begin
               op0Reg <= '0;
               op1Reg <= '0;
            end else if (adv) begin
               op0Reg <= op0Ext;
               op1Reg <= op1Ext;
            end
         end

         if (NUM_STAGE == 2) begin : g_direct
            assign finalProd = mulExt(op0Reg, op1Reg);
         end else begin : g_retime
            logic [ProdWidth-1:0] prodPipe [NUM_STAGE-2];

            // The multiply lands in the first product register; the rest are
            // pure retiming registers that give synthesis room to spread the
            // multiplier across stages.
            always_ff @(posedge ap_clk) begin
               if (ap_rst) begin
                  for (int i = 0; i < NUM_STAGE - 2; i++) begin
                     prodPipe[i] <= '0;
                  end
               end else if (adv) begin
                  prodPipe[0] <= mulExt(op0Reg, op1Reg);
                  for (int i = 1; i < NUM_STAGE - 2; i++) begin
                     prodPipe[i] <= prodPipe[i-1];
                  end
               end
            end

            assign finalProd = prodPipe[NUM_STAGE-3];
         end
      end
   endgenerate

   fpga_top_mul_pipe_reduce #(
      .IN_WIDTH      (ProdWidth),
      .DOUT_WIDTH    (DOUT_WIDTH),
      .RESULT_SIGNED (ResultSigned),
      .SATURATE      (SATURATE)
   ) uReduce (
      .prod (finalProd),
      .dout (redDout),
      .ovf  (redOvf)
   );

   // Final stage registers the reduced result and its overflow flag together
   // so they stay aligned with out_valid and hold steady during a stall.
   always_ff @(posedge ap_clk) begin
      if (ap_rst) begin
         doutReg <= '0;
         ovfReg  <= 1'b0;
      end else if (adv) begin
         doutReg <= redDout;
         ovfReg  <= redOvf;
      end
   end

endmodule

// File: tb/tb_fpga_top_mul_pipe.sv
// ---------------------------------------------------------------------------
// tb_fpga_top_mul_pipe
// Directed bench for fpga_top_mul_pipe. Four instances share clock and reset:
//   A: default parameters (unsigned, truncate, 3 stages)
//   B: defaults with SATURATE=1, driven with the same inputs as A
//   C: both operands signed, SATURATE=1
//   D: defaults with NUM_STAGE=1
// Inputs are driven 1ns after a rising edge and captured at the next edge;
// outputs are sampled away from the rising edge.
// ---------------------------------------------------------------------------
module tb_fpga_top_mul_pipe;

   logic ap_clk = 1'b0;
   logic ap_rst;

   always #5 ap_clk = ~ap_clk;

   logic       vA, rA;
   logic [9:0] d0A;
   logic [8:0] d1A;
   logic       inReadyA, outValidA, ovfA;
   logic [13:0] doutA;
   logic       inReadyB, outValidB, ovfB;
   logic [13:0] doutB;

   logic       vC, rC;
   logic [9:0] d0C;
   logic [8:0] d1C;
   logic       inReadyC, outValidC, ovfC;
   logic [13:0] doutC;

   logic       vD, rD;
   logic [9:0] d0D;
   logic [8:0] d1D;
   logic       inReadyD, outValidD, ovfD;
   logic [13:0] doutD;

   int checks = 0;
   int passes = 0;

   fpga_top_mul_pipe uDutA (
      .ap_clk(ap_clk), .ap_rst(ap_rst), .in_valid(vA), .in_ready(inReadyA),
      .din0(d0A), .din1(d1A), .out_valid(outValidA), .out_ready(rA),
      .dout(doutA), .ovf(ovfA));

   fpga_top_mul_pipe #(.SATURATE(1)) uDutB (
      .ap_clk(ap_clk), .ap_rst(ap_rst), .in_valid(vA), .in_ready(inReadyB),
      .din0(d0A), .din1(d1A), .out_valid(outValidB), .out_ready(rA),
      .dout(doutB), .ovf(ovfB));

   fpga_top_mul_pipe #(.SIGNED0(1), .SIGNED1(1), .SATURATE(1)) uDutC (
      .ap_clk(ap_clk), .ap_rst(ap_rst), .in_valid(vC), .in_ready(inReadyC),
      .din0(d0C), .din1(d1C), .out_valid(outValidC), .out_ready(rC),
      .dout(doutC), .ovf(ovfC));

   fpga_top_mul_pipe #(.NUM_STAGE(1)) uDutD (
      .ap_clk(ap_clk), .ap_rst(ap_rst), .in_valid(vD), .in_ready(inReadyD),
      .din0(d0D), .din1(d1D), .out_valid(outValidD), .out_ready(rD),
      .dout(doutD), .ovf(ovfD));

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge ap_clk);
      #1;
   endtask

   task automatic test_reset();
      ap_rst = 1'b1;
      tick();
      checks++;
      if (inReadyA !== 1'b0) $display("[TB] FAIL reset_in_ready got=%0b want=0", inReadyA);
      else passes++;
      checks++;
      if (inReadyD !== 1'b0) $display("[TB] FAIL reset_in_ready_d got=%0b want=0", inReadyD);
      else passes++;
      checks++;
      if (outValidA !== 1'b0 || doutA !== 14'd0 || ovfA !== 1'b0)
         $display("[TB] FAIL reset_outputs got valid=%0b dout=%0d ovf=%0b want 0/0/0", outValidA, doutA, ovfA);
      else passes++;
      ap_rst = 1'b0;
      #1;
      checks++;
      if (inReadyA !== 1'b1) $display("[TB] FAIL post_reset_in_ready got=%0b want=1", inReadyA);
      else passes++;
      tick();
      checks++;
      if (outValidA !== 1'b0 || doutA !== 14'd0 || ovfA !== 1'b0 || outValidC !== 1'b0 || outValidD !== 1'b0)
         $display("[TB] FAIL post_reset_outputs got validA=%0b dout=%0d ovf=%0b validC=%0b validD=%0b want all 0",
                  outValidA, doutA, ovfA, outValidC, outValidD);
      else passes++;
   endtask

   task automatic test_basic();
      rA = 1'b1; vA = 1'b1; d0A = 10'd100; d1A = 9'd50;
      tick();
      vA = 1'b0;
      checks++;
      if (outValidA !== 1'b0) $display("[TB] FAIL basic_early_1 got=%0b want=0", outValidA);
      else passes++;
      tick();
      checks++;
      if (outValidA !== 1'b0) $display("[TB] FAIL basic_early_2 got=%0b want=0", outValidA);
      else passes++;
      tick();
      checks++;
      if (outValidA !== 1'b1 || doutA !== 14'd5000 || ovfA !== 1'b0)
         $display("[TB] FAIL basic_result got valid=%0b dout=%0d ovf=%0b want 1/5000/0", outValidA, doutA, ovfA);
      else passes++;
      checks++;
      if (outValidB !== 1'b1 || doutB !== 14'd5000 || ovfB !== 1'b0)
         $display("[TB] FAIL basic_result_sat got valid=%0b dout=%0d ovf=%0b want 1/5000/0", outValidB, doutB, ovfB);
      else passes++;
      tick();
      checks++;
      if (outValidA !== 1'b0) $display("[TB] FAIL basic_drain got=%0b want=0", outValidA);
      else passes++;
   endtask

   task automatic test_overflow();
      rA = 1'b1; vA = 1'b1; d0A = 10'd1023; d1A = 9'd511;
      tick();
      vA = 1'b0;
      tick();
      tick();
      checks++;
      if (outValidA !== 1'b1 || doutA !== 14'h3A01 || ovfA !== 1'b1)
         $display("[TB] FAIL ovf_truncate got valid=%0b dout=%0h ovf=%0b want 1/3a01/1", outValidA, doutA, ovfA);
      else passes++;
      checks++;
      if (outValidB !== 1'b1 || doutB !== 14'h3FFF || ovfB !== 1'b1)
         $display("[TB] FAIL ovf_saturate got valid=%0b dout=%0h ovf=%0b want 1/3fff/1", outValidB, doutB, ovfB);
      else passes++;
      tick();
   endtask

   task automatic test_signed();
      logic [9:0]  inA [3] = '{10'h200, 10'h200, 10'h3FD};
      logic [8:0]  inB [3] = '{9'h100, 9'h0FF, 9'h005};
      logic [13:0] expD [3] = '{14'h1FFF, 14'h2000, 14'h3FF1};
      logic        expO [3] = '{1'b1, 1'b1, 1'b0};
      rC = 1'b1;
      for (int i = 0; i < 3; i++) begin
         vC = 1'b1; d0C = inA[i]; d1C = inB[i];
         tick();
      end
      vC = 1'b0;
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (outValidC !== 1'b1 || doutC !== expD[i] || ovfC !== expO[i])
            $display("[TB] FAIL signed_%0d got valid=%0b dout=%0h ovf=%0b want 1/%0h/%0b",
                     i, outValidC, doutC, ovfC, expD[i], expO[i]);
         else passes++;
         tick();
      end
      checks++;
      if (outValidC !== 1'b0) $display("[TB] FAIL signed_drain got=%0b want=0", outValidC);
      else passes++;
   endtask

   task automatic test_backpressure();
      int expProd [8] = '{0, 2, 6, 12, 20, 30, 42, 56};
      int sent = 0;
      int got = 0;
      int readyErrs = 0;
      int stableErrs = 0;
      int stallCycles = 0;
      logic prevStall = 1'b0;
      logic [13:0] prevDout = '0;
      for (int cyc = 0; cyc < 40; cyc++) begin
         rA  = !(cyc >= 4 && cyc <= 8);
         vA  = (sent < 8);
         d0A = 10'(sent);
         d1A = 9'(sent + 1);
         #1;
         if (outValidA && !rA) stallCycles++;
         if (inReadyA !== !(outValidA && !rA)) readyErrs++;
         if (prevStall && (outValidA !== 1'b1 || doutA !== prevDout)) stableErrs++;
         prevStall = outValidA && !rA;
         prevDout  = doutA;
         if (vA && inReadyA) sent++;
         if (outValidA && rA) begin
            if (got < 8) begin
               checks++;
               if (doutA !== 14'(expProd[got]) || ovfA !== 1'b0)
                  $display("[TB] FAIL bp_result_%0d got dout=%0d ovf=%0b want %0d/0", got, doutA, ovfA, expProd[got]);
               else passes++;
            end
            got++;
         end
         tick();
      end
      vA = 1'b0;
      rA = 1'b1;
      checks++;
      if (got !== 8 || sent !== 8) $display("[TB] FAIL bp_count got results=%0d sent=%0d want 8/8", got, sent);
      else passes++;
      checks++;
      if (readyErrs !== 0) $display("[TB] FAIL bp_in_ready got errors=%0d want 0", readyErrs);
      else passes++;
      checks++;
      if (stableErrs !== 0) $display("[TB] FAIL bp_stall_stable got errors=%0d want 0", stableErrs);
      else passes++;
      checks++;
      if (stallCycles !== 5) $display("[TB] FAIL bp_stall_cycles got=%0d want=5", stallCycles);
      else passes++;
   endtask

   task automatic test_reset_mid();
      int seen = 0;
      int lat = 1;
      rA = 1'b1;
      vA = 1'b1; d0A = 10'd7;  d1A = 9'd9;
      tick();
      d0A = 10'd11; d1A = 9'd13;
      tick();
      vA = 1'b0;
      ap_rst = 1'b1;
      #1;
      checks++;
      if (inReadyA !== 1'b0) $display("[TB] FAIL rst_mid_in_ready got=%0b want=0", inReadyA);
      else passes++;
      tick();
      ap_rst = 1'b0;
      #1;
      checks++;
      if (outValidA !== 1'b0 || doutA !== 14'd0) $display("[TB] FAIL rst_mid_valid got valid=%0b dout=%0d want 0/0", outValidA, doutA);
      else passes++;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (outValidA) seen++;
      end
      checks++;
      if (seen !== 0) $display("[TB] FAIL rst_mid_stale got=%0d want=0", seen);
      else passes++;
      vA = 1'b1; d0A = 10'd3; d1A = 9'd4;
      tick();
      vA = 1'b0;
      while (!outValidA && lat < 10) begin
         tick();
         lat++;
      end
      checks++;
      if (lat !== 3 || doutA !== 14'd12) $display("[TB] FAIL rst_mid_latency got lat=%0d dout=%0d want 3/12", lat, doutA);
      else passes++;
      tick();
   endtask

   task automatic test_back_to_back();
      logic [9:0]  inA [4] = '{10'd2, 10'd4, 10'd6, 10'd8};
      logic [8:0]  inB [4] = '{9'd3, 9'd5, 9'd7, 9'd9};
      logic [13:0] expD [4] = '{14'd6, 14'd20, 14'd42, 14'd72};
      rD = 1'b1;
      for (int i = 0; i < 4; i++) begin
         vD = 1'b1; d0D = inA[i]; d1D = inB[i];
         tick();
         checks++;
         if (outValidD !== 1'b1 || doutD !== expD[i] || ovfD !== 1'b0)
            $display("[TB] FAIL b2b_%0d got valid=%0b dout=%0d ovf=%0b want 1/%0d/0", i, outValidD, doutD, ovfD, expD[i]);
         else passes++;
      end
      vD = 1'b0;
      tick();
      checks++;
      if (outValidD !== 1'b0) $display("[TB] FAIL b2b_drain got=%0b want=0", outValidD);
      else passes++;
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL timeout got=running want=finished");
      $fatal(1, "[TB] timeout");
   end

   initial begin
      ap_rst = 1'b1;
      vA = 1'b0; rA = 1'b1; d0A = '0; d1A = '0;
      vC = 1'b0; rC = 1'b1; d0C = '0; d1C = '0;
      vD = 1'b0; rD = 1'b1; d0D = '0; d1D = '0;
      test_reset();
      test_basic();
      test_overflow();
      test_signed();
      test_backpressure();
      test_reset_mid();
      test_back_to_back();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
